// File: rtl/xor_parity_accum.sv
// Streaming XOR-reduction engine: folds a frame of words into column parity, reduction parity
// and a saturating word count. Define XORP_ODD_PARITY_EN for odd reduction parity (reset value 1).
module xor_parity_accum #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_parity_word,
  output logic              out_parity_bit,
  output logic [CNT_W-1:0]  out_count
);

`ifdef XORP_ODD_PARITY_EN
  localparam logic PARITY_SENSE = 1'b1;
`else
  localparam logic PARITY_SENSE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return CNT_MAX;
    end
    return c + 1'b1;
  endfunction

  function automatic logic reduce_parity(input logic [DATA_W-1:0] w);
    return (^w) ^ PARITY_SENSE;
  endfunction

  logic [DATA_W-1:0] acc_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] word_p1;
  logic              bit_p1;
  logic [CNT_W-1:0]  count_p1;

  logic              in_xfer;
  logic              out_xfer;
  logic              frame_done;
  logic [DATA_W-1:0] frame_word;
  logic [CNT_W-1:0]  frame_cnt;

  // The single output slot can refill in the same cycle it drains, so ready looks at out_ready.
  assign in_ready   = !vld_p1 || out_ready;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = vld_p1 && out_ready;
  assign frame_done = in_xfer && in_last;
  assign frame_word = acc_p0 ^ in_data;
  assign frame_cnt  = sat_inc(cnt_p0);

  // Stage p0: running accumulation of the open frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (in_xfer) begin
      if (in_last) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= frame_word;
        cnt_p0 <= frame_cnt;
      end
    end
  end

  // Stage p1: held frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      word_p1  <= '0;
      bit_p1   <= PARITY_SENSE;
      count_p1 <= '0;
    end else if (frame_done) begin
      vld_p1   <= 1'b1;
      word_p1  <= frame_word;
      bit_p1   <= reduce_parity(frame_word);
      count_p1 <= frame_cnt;
    end else if (out_xfer) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid       = vld_p1;
  assign out_parity_word = word_p1;
  assign out_parity_bit  = bit_p1;
  assign out_count       = count_p1;

endmodule
